spi_mem_cmd_ctrl: RTL and testbench

Byte-level command sequencer between the SPI slave shifter and the program/data memory of the 8-bit computer.
- Decodes the serial-flash-style protocol: 0x02 write or 0x03 read, then a 4-byte address MSB-first, then data (reads also take one dummy byte).
- Generates single-beat memory requests with address auto-increment.
- Prefetches read data for the shifter and flags protocol errors.

---
 rtl/spi_mem_pkg.sv | 19 +
 rtl/spi_mem_req_port.sv | 67 ++++++
 rtl/spi_mem_cmd_ctrl.sv | 178 +++++++++++++++++
 tb/tb_spi_mem_cmd_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared opcodes, sequencer states and protocol constants for the SPI memory command path.
package spi_mem_pkg;

    localparam logic [7:0] CMD_WR = 8'h02;
    localparam logic [7:0] CMD_RD = 8'h03;

    localparam int unsigned DUMMY_BYTES = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDUMMY,
        RDATA,
        IGNORE
    } state_e;

endpackage

// File: rtl/spi_mem_req_port.sv
// Single-beat memory request holding register with overrun detection.
// A request is frozen until acked; an issue while one is outstanding is dropped and flagged.
module spi_mem_req_port #(
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          issue_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    input  logic          ack_i,
    output logic          req_o,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [7:0]    wdata_o,
    output logic          ack_o,
    output logic          ovr_o
);

    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          free;
    logic          accept;

    // An ack in the same cycle frees the slot, so a new issue is accepted without overrun.
    always_comb begin
        ack_o   = ack_i & req_q;
        free    = ~req_q | ack_i;
        accept  = issue_i & free;
        ovr_o   = issue_i & ~free;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            req_d   = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end else if (ack_o) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/spi_mem_cmd_ctrl.sv
// Byte-level SPI command sequencer: decodes write/read opcodes, a 4-byte address and data,
// and drives single-beat memory requests with address auto-increment and read prefetch.
module spi_mem_cmd_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MEM_AW = 8,
    parameter logic [7:0]  CMD_WR = spi_mem_pkg::CMD_WR,
    parameter logic [7:0]  CMD_RD = spi_mem_pkg::CMD_RD
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cs_active,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              err_cmd,
    output logic              err_ovr
);

    import spi_mem_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              rd_mode_q, rd_mode_d;
    logic [7:0]        tx_q, tx_d;
    logic              err_cmd_q, err_cmd_d;
    logic              err_ovr_q;
    logic              armed_q, armed_d;
    logic              start;
    logic              issue;
    logic              issue_we;
    logic              ack_v;
    logic              ovr;

    spi_mem_req_port #(
        .AW (MEM_AW)
    ) u_req_port (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .issue_i (issue),
        .we_i    (issue_we),
        .addr_i  (addr_d[MEM_AW-1:0]),
        .wdata_i (rx_data),
        .ack_i   (mem_ack),
        .req_o   (mem_req),
        .we_o    (mem_we),
        .addr_o  (mem_addr),
        .wdata_o (mem_wdata),
        .ack_o   (ack_v),
        .ovr_o   (ovr)
    );

    // The ack is applied to addr_d first, so a request issued in the same cycle uses the next address.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rd_mode_d = rd_mode_q;
        tx_d      = tx_q;
        err_cmd_d = err_cmd_q;
        armed_d   = armed_q;
        start     = 1'b0;
        issue     = 1'b0;
        issue_we  = 1'b0;

        if (ack_v) begin
            addr_d = addr_q + ADDR_W'(1);
            if (!mem_we && (state_q == RDUMMY || state_q == RDATA)) begin
                tx_d = mem_rdata;
            end
        end

        if (!cs_active) begin
            armed_d = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // armed_q remembers a fresh select so the start can wait for an old ack.
                    if (armed_q && !mem_req) begin
                        start     = 1'b1;
                        armed_d   = 1'b0;
                        err_cmd_d = 1'b0;
                        tx_d      = '0;
                        state_d   = CMD;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        cnt_d = '0;
                        if (rx_data == CMD_WR) begin
                            rd_mode_d = 1'b0;
                            state_d   = ADDR;
                        end else if (rx_data == CMD_RD) begin
                            rd_mode_d = 1'b1;
                            state_d   = ADDR;
                        end else begin
                            err_cmd_d = 1'b1;
                            state_d   = IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr_d = {addr_d[ADDR_W-9:0], rx_data};
                        cnt_d  = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            cnt_d = '0;
                            if (rd_mode_q) begin
                                issue   = 1'b1;
                                state_d = RDUMMY;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDUMMY: begin
                    if (rx_valid) begin
                        if (cnt_q == 2'(DUMMY_BYTES - 1)) begin
                            issue   = 1'b1;
                            state_d = RDATA;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                RDATA: begin
                    issue = rx_valid;
                end
                WDATA: begin
                    issue    = rx_valid;
                    issue_we = 1'b1;
                end
                IGNORE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_mode_q <= 1'b0;
            tx_q      <= '0;
            err_cmd_q <= 1'b0;
            err_ovr_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            rd_mode_q <= rd_mode_d;
            tx_q      <= tx_d;
            err_cmd_q <= err_cmd_d;
            err_ovr_q <= start ? 1'b0 : (err_ovr_q | ovr);
            armed_q   <= armed_d;
        end
    end

    assign tx_data = (state_q == RDUMMY || state_q == RDATA) ? tx_q : '0;
    assign busy    = (state_q != IDLE) | mem_req;
    assign err_cmd = err_cmd_q;
    assign err_ovr = err_ovr_q;

endmodule

// File: tb/tb_spi_mem_cmd_ctrl.sv
// Self-checking bench for spi_mem_cmd_ctrl: shifter driver, memory responder and a
// transaction-level reference model of the protocol.
module tb_spi_mem_cmd_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       cs_active;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       busy;
    logic       err_cmd;
    logic       err_ovr;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned ack_lat = 0;
    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];

    logic [7:0] txq[$];
    logic [7:0] capq[$];
    logic [7:0] wr_a[$], wr_d[$], rd_a[$];
    logic [7:0] ewr_a[$], ewr_d[$], erd_a[$], exp_cap[$];
    logic       exp_err_cmd;

    int unsigned r_wc  = 0;
    logic        r_preq = 1'b0;
    logic        r_pwe;
    logic [7:0]  r_pa, r_pd;

    spi_mem_cmd_ctrl #(
        .ADDR_W (32),
        .MEM_AW (8),
        .CMD_WR (8'h02),
        .CMD_RD (8'h03)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cs_active (cs_active),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .err_cmd   (err_cmd),
        .err_ovr   (err_ovr)
    );

    always #5 sys_clk = ~sys_clk;

    // Memory responder: acks ack_lat cycles late; also checks that a request stays frozen until acked.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                r_preq = 1'b0;
            end else if (r_preq && !mem_ack) begin
                n_cmp++;
                if (mem_req !== 1'b1 || mem_addr !== r_pa || mem_we !== r_pwe || mem_wdata !== r_pd) begin
                    n_err++;
                    $display("FAIL req_hold: req=%b addr=%h we=%b wd=%h, required req=1 addr=%h we=%b wd=%h",
                             mem_req, mem_addr, mem_we, mem_wdata, r_pa, r_pwe, r_pd);
                end
            end
            r_preq  = mem_req & ~sys_rst;
            r_pa    = mem_addr;
            r_pwe   = mem_we;
            r_pd    = mem_wdata;
            mem_ack = 1'b0;
            if (mem_req === 1'b1 && !sys_rst) begin
                if (r_wc >= ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    r_wc      = 0;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wr_a.push_back(mem_addr);
                        wr_d.push_back(mem_wdata);
                    end else begin
                        rd_a.push_back(mem_addr);
                    end
                end else begin
                    r_wc++;
                end
            end else begin
                r_wc = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); rd_a.delete(); capq.delete();
    endtask

    task automatic cs_open();
        @(negedge sys_clk);
        cs_active = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        rx_data  = b;
        rx_valid = 1'b1;
        capq.push_back(tx_data);
        @(negedge sys_clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic cs_close();
        int unsigned t = 0;
        cs_active = 1'b0;
        @(negedge sys_clk);
        while (busy === 1'b1 && t < 500) begin
            @(negedge sys_clk);
            t++;
        end
        if (busy !== 1'b0) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: busy=%b after cs drop, required 0", busy);
        end
    endtask

    task automatic drive_txn(input int unsigned gap);
        clear_logs();
        cs_open();
        foreach (txq[i]) send_byte(txq[i], gap);
        cs_close();
    endtask

    // Transaction-level reference: opcode, 32-bit big-endian address, then data or dummy+fillers.
    function automatic void model_txn();
        logic [7:0]  op;
        logic [31:0] a, wa;
        int          n;
        ewr_a.delete(); ewr_d.delete(); erd_a.delete(); exp_cap.delete();
        exp_err_cmd = 1'b0;
        n = txq.size();
        for (int i = 0; i < n; i++) exp_cap.push_back(8'h00);
        if (n == 0) return;
        op = txq[0];
        if (op != 8'h02 && op != 8'h03) begin
            exp_err_cmd = 1'b1;
            return;
        end
        if (n < 5) return;
        a = {txq[1], txq[2], txq[3], txq[4]};
        if (op == 8'h02) begin
            for (int i = 5; i < n; i++) begin
                wa = a + 32'(i - 5);
                ewr_a.push_back(wa[7:0]);
                ewr_d.push_back(txq[i]);
                ref_mem[wa[7:0]] = txq[i];
            end
        end else begin
            for (int k = 0; k <= n - 5; k++) begin
                wa = a + 32'(k);
                erd_a.push_back(wa[7:0]);
            end
            for (int i = 5; i < n; i++) begin
                wa = a + 32'(i - 5);
                exp_cap[i] = ref_mem[wa[7:0]];
            end
        end
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1; cs_active = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (2) @(negedge sys_clk);
        n_cmp++;
        if ({tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err_cmd, err_ovr} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: tx=%h req=%b we=%b addr=%h wd=%h busy=%b ec=%b eo=%b, required all 0",
                     tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err_cmd, err_ovr);
        end
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_cmp++;
        if ({mem_req, busy, err_cmd, err_ovr} !== 4'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: req=%b busy=%b ec=%b eo=%b, required 0", mem_req, busy, err_cmd, err_ovr);
        end
    endtask

    task automatic test_write();
        ack_lat = 0;
        txq = '{8'h02, 8'h04, 8'h03, 8'h02, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        drive_txn(4);
        model_txn();
        n_cmp++;
        if (wr_a.size() != 5 || rd_a.size() != 0) begin
            n_err++;
            $display("FAIL write_count: writes=%0d reads=%0d, required 5 and 0", wr_a.size(), rd_a.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (wr_a[i] !== 8'(i + 1) || wr_d[i] !== 8'(i + 1)) begin
                    n_err++;
                    $display("FAIL write_beat%0d: addr=%h data=%h, required %h/%h", i, wr_a[i], wr_d[i], 8'(i + 1), 8'(i + 1));
                end
            end
        end
        n_cmp++;
        if (err_cmd !== 1'b0 || err_ovr !== 1'b0) begin
            n_err++;
            $display("FAIL write_errs: ec=%b eo=%b, required 0 0", err_cmd, err_ovr);
        end
    endtask

    task automatic test_readback();
        ack_lat = 1;
        txq = '{8'h03, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
        drive_txn(4);
        model_txn();
        n_cmp++;
        if (capq.size() != 10) begin
            n_err++;
            $display("FAIL rb_capcount: %0d, required 10", capq.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (capq[i] !== ((i < 5) ? 8'h00 : 8'(i - 4))) begin
                    n_err++;
                    $display("FAIL rb_tx%0d: tx=%h, required %h", i, capq[i], (i < 5) ? 8'h00 : 8'(i - 4));
                end
            end
        end
        n_cmp++;
        if (rd_a.size() != 6 || wr_a.size() != 0) begin
            n_err++;
            $display("FAIL rb_readcount: reads=%0d writes=%0d, required 6 and 0", rd_a.size(), wr_a.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (rd_a[i] !== 8'(i + 1)) begin
                    n_err++;
                    $display("FAIL rb_raddr%0d: %h, required %h", i, rd_a[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_bad_opcode();
        ack_lat = 0;
        txq = '{8'h9F, 8'h11, 8'h22, 8'h33, 8'h44};
        drive_txn(4);
        n_cmp++;
        if (err_cmd !== 1'b1 || wr_a.size() != 0 || rd_a.size() != 0) begin
            n_err++;
            $display("FAIL bad_opcode: ec=%b writes=%0d reads=%0d, required 1 0 0", err_cmd, wr_a.size(), rd_a.size());
        end
        txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h20, 8'h77};
        drive_txn(4);
        model_txn();
        n_cmp++;
        if (err_cmd !== 1'b0 || wr_a.size() != 1 || wr_a[0] !== 8'h20 || wr_d[0] !== 8'h77) begin
            n_err++;
            $display("FAIL errcmd_clear: ec=%b writes=%0d, required ec=0 and one write 20:77", err_cmd, wr_a.size());
        end
    endtask

    task automatic test_cs_abort();
        ack_lat = 0;
        txq = '{8'h02, 8'h00, 8'h00};
        drive_txn(4);
        n_cmp++;
        if (wr_a.size() != 0 || rd_a.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL cs_abort: writes=%0d reads=%0d busy=%b, required 0 0 0", wr_a.size(), rd_a.size(), busy);
        end
        txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hAA, 8'hBB};
        drive_txn(4);
        model_txn();
        n_cmp++;
        if (wr_a.size() != 2 || wr_a[0] !== 8'hFF || wr_d[0] !== 8'hAA || wr_a[1] !== 8'h00 || wr_d[1] !== 8'hBB) begin
            n_err++;
            $display("FAIL addr_wrap: writes=%0d first=%h:%h, required FF:AA then 00:BB",
                     wr_a.size(), (wr_a.size() > 0) ? wr_a[0] : 8'hxx, (wr_d.size() > 0) ? wr_d[0] : 8'hxx);
        end
    endtask

    task automatic test_slow_mem();
        int unsigned t = 0;
        ack_lat = 20;
        clear_logs();
        cs_open();
        foreach (txq[i]) txq.delete(i);
        txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h40};
        foreach (txq[i]) send_byte(txq[i], 1);
        send_byte(8'h11, 9);
        send_byte(8'h22, 9);
        while (mem_req === 1'b1 && t < 100) begin
            @(negedge sys_clk);
            t++;
        end
        send_byte(8'h33, 1);
        cs_close();
        ref_mem[8'h40] = 8'h11;
        ref_mem[8'h41] = 8'h33;
        n_cmp++;
        if (err_ovr !== 1'b1) begin
            n_err++;
            $display("FAIL slow_ovr: eo=%b, required 1", err_ovr);
        end
        n_cmp++;
        if (wr_a.size() != 2 || wr_a[0] !== 8'h40 || wr_d[0] !== 8'h11 || wr_a[1] !== 8'h41 || wr_d[1] !== 8'h33) begin
            n_err++;
            $display("FAIL slow_writes: writes=%0d, required 40:11 then 41:33 with 22 dropped", wr_a.size());
        end
    endtask

    task automatic test_reset_mid();
        ack_lat = 20;
        clear_logs();
        cs_open();
        txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h50};
        foreach (txq[i]) send_byte(txq[i], 1);
        send_byte(8'h66, 0);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_req: req=%b, required 1 before reset", mem_req);
        end
        #2 sys_rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy, err_cmd, err_ovr} !== '0) begin
            n_err++;
            $display("FAIL rstmid_async: req=%b busy=%b addr=%h wd=%h, required all outputs 0", mem_req, busy, mem_addr, mem_wdata);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0; cs_active = 1'b0; rx_valid = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_cmp++;
        if (wr_a.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_nowrite: writes=%0d, required 0", wr_a.size());
        end
        ack_lat = 0;
        txq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h60, 8'h5A, 8'h5B};
        drive_txn(4);
        model_txn();
        n_cmp++;
        if (wr_a.size() != 2 || wr_a[0] !== 8'h60 || wr_d[0] !== 8'h5A || wr_a[1] !== 8'h61 || wr_d[1] !== 8'h5B) begin
            n_err++;
            $display("FAIL rstmid_clean: writes=%0d, required 60:5A then 61:5B", wr_a.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 30; t++) begin
            int unsigned sel, nd;
            logic [31:0] a;
            logic [7:0]  op;
            ack_lat = $urandom_range(0, 2);
            sel = $urandom_range(0, 7);
            a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
            nd  = $urandom_range(0, 6);
            op  = (sel < 4) ? 8'h02 : (sel < 7) ? 8'h03 : 8'($urandom_range(4, 255));
            txq = '{op, a[31:24], a[23:16], a[15:8], a[7:0]};
            if (op == 8'h03) txq.push_back(8'($urandom));
            for (int k = 0; k < int'(nd); k++) txq.push_back(8'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                while (txq.size() > 2) void'(txq.pop_back());
            end
            drive_txn(4);
            model_txn();
            n_cmp++;
            if (wr_a.size() != ewr_a.size() || rd_a.size() != erd_a.size() || capq.size() != exp_cap.size()) begin
                n_err++;
                $display("FAIL rnd%0d_counts: w=%0d r=%0d c=%0d, required w=%0d r=%0d c=%0d", t,
                         wr_a.size(), rd_a.size(), capq.size(), ewr_a.size(), erd_a.size(), exp_cap.size());
            end else begin
                foreach (ewr_a[i]) begin
                    n_cmp++;
                    if (wr_a[i] !== ewr_a[i] || wr_d[i] !== ewr_d[i]) begin
                        n_err++;
                        $display("FAIL rnd%0d_w%0d: %h:%h, required %h:%h", t, i, wr_a[i], wr_d[i], ewr_a[i], ewr_d[i]);
                    end
                end
                foreach (erd_a[i]) begin
                    n_cmp++;
                    if (rd_a[i] !== erd_a[i]) begin
                        n_err++;
                        $display("FAIL rnd%0d_r%0d: %h, required %h", t, i, rd_a[i], erd_a[i]);
                    end
                end
                foreach (exp_cap[i]) begin
                    n_cmp++;
                    if (capq[i] !== exp_cap[i]) begin
                        n_err++;
                        $display("FAIL rnd%0d_tx%0d: %h, required %h", t, i, capq[i], exp_cap[i]);
                    end
                end
            end
            n_cmp++;
            if (err_cmd !== exp_err_cmd || err_ovr !== 1'b0) begin
                n_err++;
                $display("FAIL rnd%0d_errs: ec=%b eo=%b, required ec=%b eo=0", t, err_cmd, err_ovr, exp_err_cmd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write();
        test_readback();
        test_bad_opcode();
        test_cs_abort();
        test_slow_mem();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
